// File: rtl/temp_sensor_read_ctrl.sv
// Read sequencer for a CS/SCK/SO temperature sensor. It frames reads, enforces the
// conversion interval, and merges on-demand requests with auto-poll.
module temp_sensor_read_ctrl #(
  parameter int C_TEMP_SENSOR_PO_WL   = 16,
  parameter int C_TEMP_SENSOR_DATA_WL = 13,
  parameter int C_SCK_HALF_DIV        = 5,
  parameter int C_CS_SETUP_CYC        = 5,
  parameter int C_CS_HOLD_CYC         = 5,
  parameter int C_CONV_WAIT_CYC       = 1000
) (
  input  logic                             CLK_IN,
  input  logic                             RST_IN,
  input  logic                             Read_req_IN,
  input  logic                             Poll_en_IN,
  input  logic                             Temp_sensor_SO_IN,
  output logic                             Temp_sensor_CS_OUT,
  output logic                             Temp_sensor_SCK_OUT,
  output logic [C_TEMP_SENSOR_DATA_WL-1:0] Temp_data_OUT,
  output logic                             Data_valid_OUT,
  output logic                             Frame_err_OUT,
  output logic                             Busy_OUT
);

  localparam int PO_WL = C_TEMP_SENSOR_PO_WL;
  localparam int DW    = C_TEMP_SENSOR_DATA_WL;
  localparam int CNT_MAX = C_CONV_WAIT_CYC + C_CS_SETUP_CYC + C_CS_HOLD_CYC + C_SCK_HALF_DIV;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int BIT_W = $clog2(PO_WL + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(C_CS_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(C_SCK_HALF_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(C_CS_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(C_CONV_WAIT_CYC - 1);
  localparam logic [BIT_W-1:0] BITS_ALL   = BIT_W'(PO_WL);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, SCK_HIGH, SCK_LOW, CS_HOLD, CONV_WAIT
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [BIT_W-1:0]  bits, bits_n;
  logic [PO_WL-1:0]  shift, shift_n;
  logic              pend, pend_n;
  logic              cs_n, sck_n, valid_n, err_n;
  logic [DW-1:0]     data_n;
  logic              start;
  logic [PO_WL-1:0]  shift_in;

  // Requests, a latched request and auto-poll all collapse into one frame start.
  assign start    = Read_req_IN | pend | Poll_en_IN;
  assign shift_in = {shift[PO_WL-2:0], Temp_sensor_SO_IN};
  assign Busy_OUT = (state != IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    bits_n  = bits;
    shift_n = shift;
    pend_n  = pend | (Read_req_IN & (state != IDLE));
    cs_n    = Temp_sensor_CS_OUT;
    sck_n   = Temp_sensor_SCK_OUT;
    valid_n = 1'b0;
    data_n  = Temp_data_OUT;
    err_n   = Frame_err_OUT;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) begin
          state_n = CS_SETUP;
          cs_n    = 1'b0;
          pend_n  = 1'b0;
          bits_n  = '0;
        end
      end
      CS_SETUP: if (cnt == SETUP_LAST) begin
        shift_n = shift_in;
        bits_n  = BIT_W'(1);
        sck_n   = 1'b1;
        cnt_n   = '0;
        state_n = SCK_HIGH;
      end
      SCK_HIGH: if (cnt == HALF_LAST) begin
        sck_n   = 1'b0;
        cnt_n   = '0;
        state_n = SCK_LOW;
      end
      SCK_LOW: if (cnt == HALF_LAST) begin
        cnt_n = '0;
        if (bits < BITS_ALL) begin
          // SO settled during the low half; capture it as SCK rises.
          shift_n = shift_in;
          bits_n  = bits + 1'b1;
          sck_n   = 1'b1;
          state_n = SCK_HIGH;
        end else begin
          state_n = CS_HOLD;
        end
      end
      CS_HOLD: if (cnt == HOLD_LAST) begin
        cs_n    = 1'b1;
        data_n  = shift[PO_WL-1 -: DW];
        err_n   = shift[2];
        valid_n = 1'b1;
        cnt_n   = '0;
        state_n = CONV_WAIT;
      end
      CONV_WAIT: if (cnt == CONV_LAST) begin
        cnt_n = '0;
        if (start) begin
          state_n = CS_SETUP;
          cs_n    = 1'b0;
          pend_n  = 1'b0;
          bits_n  = '0;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cs_n    = 1'b1;
        sck_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state               <= IDLE;
      cnt                 <= '0;
      bits                <= '0;
      shift               <= '0;
      pend                <= 1'b0;
      Temp_sensor_CS_OUT  <= 1'b1;
      Temp_sensor_SCK_OUT <= 1'b0;
      Temp_data_OUT       <= '0;
      Data_valid_OUT      <= 1'b0;
      Frame_err_OUT       <= 1'b0;
    end else begin
      state               <= state_n;
      cnt                 <= cnt_n;
      bits                <= bits_n;
      shift               <= shift_n;
      pend                <= pend_n;
      Temp_sensor_CS_OUT  <= cs_n;
      Temp_sensor_SCK_OUT <= sck_n;
      Temp_data_OUT       <= data_n;
      Data_valid_OUT      <= valid_n;
      Frame_err_OUT       <= err_n;
    end
  end

endmodule

// File: tb/tb_temp_sensor_read_ctrl.sv
// Bench for temp_sensor_read_ctrl: sensor model, waveform monitor and
// expected-result queue popped on each valid strobe.
module tb_temp_sensor_read_ctrl;

  logic clk = 1'b0, rst = 1'b0, req = 1'b0, poll = 1'b0, so = 1'b0;
  logic cs, sck, valid, err, busy;
  logic [12:0] data;

  temp_sensor_read_ctrl dut (
    .CLK_IN(clk), .RST_IN(rst), .Read_req_IN(req), .Poll_en_IN(poll),
    .Temp_sensor_SO_IN(so), .Temp_sensor_CS_OUT(cs), .Temp_sensor_SCK_OUT(sck),
    .Temp_data_OUT(data), .Data_valid_OUT(valid), .Frame_err_OUT(err), .Busy_OUT(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [12:0] d; logic e; } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sensor: first bit appears at CS fall, next bit after every SCK fall.
  logic [15:0] frame_word = '0;
  int idx = 0;
  always @(negedge cs) begin idx = 15; so = frame_word[15]; end
  always @(negedge sck) if (!cs) begin
    idx--;
    if (idx >= 0) so = frame_word[idx];
  end

  // Monitor
  int cyc = 0, idle_cnt = 0, busy_fall_cyc = 0, n_csfall = 0;
  int cs_len = 0, hi_len = 0, last_gap = 0, rises = 0, hi_run = 0, lo_run = 0, wbad = 0;
  int frame_len = 0, frame_rises = 0, frame_wbad = 0;
  int n_vld = 0, vld_cyc = 0, prev_vld_cyc = 0;
  logic cs_d = 1'b1, sck_d = 1'b0, busy_d = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    cyc++;
    if (!busy) idle_cnt++;
    if (busy_d && !busy) busy_fall_cyc = cyc;
    if (!cs && cs_d) begin
      last_gap = hi_len; cs_len = 0; rises = 0; hi_run = 0; lo_run = 0; wbad = 0; n_csfall++;
    end
    if (cs && !cs_d) begin
      frame_len = cs_len; frame_rises = rises; frame_wbad = wbad; hi_len = 0;
    end
    if (!cs) begin
      cs_len++;
      if (sck && !sck_d) begin
        if (rises > 0 && lo_run != 5) wbad++;
        lo_run = 0; rises++;
      end
      if (!sck && sck_d) begin
        if (hi_run != 5) wbad++;
        hi_run = 0;
      end
      if (sck) hi_run++; else lo_run++;
    end else hi_len++;
    if (valid) begin
      chk("vld_at_cs_rise", 32'(cs && !cs_d), 32'd1);
      prev_vld_cyc = vld_cyc; vld_cyc = cyc; n_vld++;
      if (sb.size() == 0) chk("sb_empty", 32'd0, 32'd1);
      else begin
        e = sb.pop_front();
        chk("data", 32'(data), 32'(e.d));
        chk("frame_err", 32'(err), 32'(e.e));
      end
    end
    cs_d = cs; sck_d = sck; busy_d = busy;
  end

  task automatic pulse_req();
    req = 1'b1; @(negedge clk); req = 1'b0;
  endtask

  task automatic wait_vld(input int target);
    int c = 0;
    while (n_vld < target && c < 3000) begin @(negedge clk); c++; end
    if (n_vld < target) chk("tmo_vld", 32'(n_vld), 32'(target));
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 3000) begin @(negedge clk); c++; end
    if (busy) chk("tmo_idle", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_cs_low();
    int c = 0;
    while (cs && c < 3000) begin @(negedge clk); c++; end
    if (cs) chk("tmo_cs_low", 32'(cs), 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_rises(input int k);
    int c = 0;
    while (rises < k && c < 500) begin @(negedge clk); c++; end
    if (rises < k) chk("tmo_rises", 32'(rises), 32'(k));
  endtask

  task automatic push(input logic [12:0] d, input logic er);
    exp_t x;
    x.d = d; x.e = er;
    sb.push_back(x);
  endtask

  task automatic chk_frame(input string tag);
    chk({tag, "_cs_len"}, 32'(frame_len), 32'd170);
    chk({tag, "_rises"}, 32'(frame_rises), 32'd16);
    chk({tag, "_sck_width"}, 32'(frame_wbad), 32'd0);
  endtask

  int mark;

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single read
    frame_word = {13'h0C80, 1'b0, 2'b11};
    push(13'h0C80, 1'b0);
    pulse_req();
    wait_vld(1);
    chk_frame("f1");
    wait_idle();
    chk("busy_after_conv", 32'(busy_fall_cyc - vld_cyc), 32'd1000);

    // Two back-to-back requests, all ones then all zeros
    frame_word = {13'h1FFF, 1'b0, 2'b00};
    push(13'h1FFF, 1'b0);
    pulse_req();
    wait_vld(2);
    wait_idle();
    frame_word = {13'h0000, 1'b0, 2'b11};
    push(13'h0000, 1'b0);
    pulse_req();
    wait_vld(3);
    chk("gap_ge_conv", 32'(last_gap >= 1000), 32'd1);
    chk_frame("f3");
    wait_idle();

    // Auto-poll, three frames, dropped during the third
    frame_word = {13'h0010, 1'b0, 2'b01};
    push(13'h0010, 1'b0); push(13'h0011, 1'b0); push(13'h0012, 1'b0);
    poll = 1'b1;
    wait_vld(4);
    frame_word = {13'h0011, 1'b0, 2'b10};
    wait_vld(5);
    chk("poll_gap1", 32'(vld_cyc - prev_vld_cyc), 32'd1170);
    frame_word = {13'h0012, 1'b0, 2'b01};
    wait_cs_low();
    repeat (20) @(negedge clk);
    poll = 1'b0;
    wait_vld(6);
    chk("poll_gap2", 32'(vld_cyc - prev_vld_cyc), 32'd1170);
    chk_frame("poll3");
    wait_idle();
    repeat (200) @(negedge clk);
    chk("poll_stopped", 32'(n_vld), 32'd6);
    chk("poll_idle_cs", 32'(cs), 32'd1);

    // Three requests during a frame collapse into one extra frame
    frame_word = {13'h0ABC, 1'b0, 2'b00};
    push(13'h0ABC, 1'b0); push(13'h0ABC, 1'b0);
    pulse_req();
    @(negedge clk);
    mark = idle_cnt;
    wait_rises(3);
    pulse_req();
    repeat (30) @(negedge clk);
    pulse_req();
    repeat (30) @(negedge clk);
    pulse_req();
    wait_vld(8);
    chk("pend_busy_held", 32'(idle_cnt - mark), 32'd0);
    chk("pend_gap", 32'(last_gap), 32'd1000);
    wait_idle();
    repeat (300) @(negedge clk);
    chk("pend_one_extra", 32'(n_vld), 32'd8);

    // Frame error bit
    frame_word = {13'h0155, 1'b1, 2'b00};
    push(13'h0155, 1'b1);
    pulse_req();
    wait_vld(9);
    wait_idle();

    // Asynchronous reset in the middle of a frame
    frame_word = {13'h0777, 1'b0, 2'b00};
    pulse_req();
    wait_cs_low();
    wait_rises(8);
    #2 rst = 1'b1;
    #1;
    chk("arst_cs", 32'(cs), 32'd1);
    chk("arst_sck", 32'(sck), 32'd0);
    chk("arst_data", 32'(data), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    mark = n_vld;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("arst_no_vld", 32'(n_vld), 32'(mark));
    frame_word = {13'h1234, 1'b0, 2'b10};
    push(13'h1234, 1'b0);
    pulse_req();
    wait_vld(mark + 1);
    chk_frame("post_rst");
    wait_idle();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/temp_sensor_read_ctrl.md
Name: temp_sensor_read_ctrl

Overview:
Master-side sequencer for the MAX6630 serial temperature sensor interface (CS/SCK/SO, 16-bit read frame, 13 data bits MSB-first).
- Generates CS and SCK from the system clock and deserialises SO.
- Enforces the sensor's minimum conversion interval between frames.
- Arbitrates on-demand read requests against free-running auto-poll, and presents the result to the CPLD register logic with a valid strobe.

Parameters:
- C_TEMP_SENSOR_PO_WL, 16: frame length in bits.
- C_TEMP_SENSOR_DATA_WL, 13: data bits at frame MSB end.
- C_SCK_HALF_DIV, 5: system clocks per SCK half-period (≥100 ns at 50 MHz; covers 80 ns SO delay); min 2.
- C_CS_SETUP_CYC, 5: clocks from CS fall to first SCK rise; min 1.
- C_CS_HOLD_CYC, 5: clocks from last SCK fall to CS rise; min 1.
- C_CONV_WAIT_CYC, 1000: clocks after CS rise before the next frame may start; min 1. Simulation value; synthesis overrides with the 0.3 s equivalent.

Ports:
- CLK_IN, input, 1: system clock, rising edge.
- RST_IN, input, 1: asynchronous reset, active-high.
- Read_req_IN, input, 1: single-cycle read request pulse.
- Poll_en_IN, input, 1: level; enables continuous back-to-back reads.
- Temp_sensor_SO_IN, input, 1: sensor serial data.
- Temp_sensor_CS_OUT, output, 1: chip select, active-low, registered.
- Temp_sensor_SCK_OUT, output, 1: serial clock, idles low, registered.
- Temp_data_OUT, output, C_TEMP_SENSOR_DATA_WL: last captured data, held between frames.
- Data_valid_OUT, output, 1: one-cycle strobe when Temp_data_OUT updates.
- Frame_err_OUT, output, 1: frame bit 2 was read as 1; updated with Data_valid_OUT.
- Busy_OUT, output, 1: high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, any state, including mid-frame):
  - CS_OUT=1, SCK_OUT=0, Temp_data_OUT=0, Data_valid_OUT=0, Frame_err_OUT=0, Busy_OUT=0.
  - State goes to IDLE; pending flag, counters and shift register are cleared.
- States: IDLE → CS_SETUP → SCK_HIGH ↔ SCK_LOW → CS_HOLD → CONV_WAIT → IDLE or CS_SETUP.
- IDLE:
  - Starts a frame if Read_req_IN=1, the pending flag is set, or Poll_en_IN=1.
  - Next cycle: CS_OUT=0 and enter CS_SETUP.
- CS_SETUP:
  - Lasts C_CS_SETUP_CYC cycles.
  - On the last cycle, sample SO into the shift LSB, set SCK_OUT=1 and enter SCK_HIGH. This sample is bit 15.
- SCK_HIGH: lasts C_SCK_HALF_DIV cycles, then SCK_OUT=0 and enter SCK_LOW.
- SCK_LOW:
  - Lasts C_SCK_HALF_DIV cycles.
  - On its last cycle, if fewer than PO_WL bits have been sampled: sample SO (shift left, SO into LSB), set SCK_OUT=1, enter SCK_HIGH.
  - Otherwise enter CS_HOLD.
  - Net effect: SO is sampled on each SCK rising edge, at least one half-period after the preceding SCK fall.
- SCK rising edges: exactly C_TEMP_SENSOR_PO_WL (16) per frame.
- CS_HOLD: lasts C_CS_HOLD_CYC cycles, then CS_OUT=1. In the same edge:
  - Temp_data_OUT ← shift[PO_WL-1 : PO_WL-DATA_WL].
  - Frame_err_OUT ← shift[2].
  - Data_valid_OUT=1 for one cycle.
  - Bits [1:0] are ignored.
- Frame length from CS fall to CS rise: C_CS_SETUP_CYC + 2·PO_WL·C_SCK_HALF_DIV + C_CS_HOLD_CYC. With defaults this is 170 clocks.
- CONV_WAIT:
  - Lasts C_CONV_WAIT_CYC cycles with CS_OUT=1.
  - On exit: if Poll_en_IN=1 or pending, drive CS_OUT=0 in the next cycle and enter CS_SETUP; clear pending. Otherwise go to IDLE.
- Read_req_IN while Busy_OUT=1 sets the pending flag.
  - Multiple requests collapse into one.
  - A request in the same cycle as the Data_valid_OUT strobe also sets pending.
- Read_req_IN and Poll_en_IN together: only one frame is started; no pending flag is set.
- Poll_en_IN deasserted mid-frame: the current frame completes, then CONV_WAIT, then IDLE (unless pending).
- SO is sampled directly. The sensor is synchronous to SCK, which this block generates, so no synchroniser is used.
- Busy_OUT is 0 only in IDLE.

Test Plan:
- Sensor model data 13'h0C80, single Read_req_IN pulse:
  - CS low for 170 clocks; exactly 16 SCK pulses, each 5 high / 5 low clocks.
  - Temp_data_OUT=13'h0C80; Data_valid_OUT pulses once, in the CS-rise cycle; Frame_err_OUT=0.
  - Busy_OUT returns to 0 after 1000 CONV_WAIT clocks.
- Data 13'h1FFF, then 13'h0000 on two successive requests:
  - Outputs 13'h1FFF then 13'h0000.
  - CS-high gap between the two frames ≥1000 clocks.
- Poll_en_IN=1 for 3 frames with data changing 13'h0010 → 13'h0011 → 13'h0012 between frames:
  - Three valid strobes, 1170 clocks apart, carrying the matching values.
  - Clearing Poll_en_IN during frame 3 still completes frame 3; the block then idles.
- Read_req_IN pulsed three times during a frame:
  - Exactly one extra frame starts, immediately after CONV_WAIT.
  - Busy_OUT stays 1 throughout.
- Force model bit 2 to 1 with data 13'h0155: Temp_data_OUT=13'h0155 and Frame_err_OUT=1.
- Assert RST_IN at SCK pulse 8:
  - CS_OUT=1 and SCK_OUT=0 asynchronously; Temp_data_OUT=0; no valid strobe.
  - After release, a new request yields a correct full frame.
